// File: rtl/cu_fetch_seq.sv
// Instruction-fetch sequencer: holds the PC, issues one word read per
// instruction, captures the returned word and hands it to decode.
// Redirects that arrive while a read is in flight are parked until the read returns.
module cu_fetch_seq #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        soc_clk,
  input  logic        IF_reset,
  input  logic        IF_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  input  logic        decode_ready,
  output logic        memfetch_start,
  output logic [31:0] addr,
  output logic [3:0]  bits_to_access,
  output logic        read_or_write,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        misaligned_fault,
  output logic        timeout_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  // Last WAIT count value tolerated before the fetch is declared lost.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        pend, pend_n;
  logic [31:0] pend_tgt, pend_tgt_n;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic [31:0] data_n, ipc_n;
  logic        valid_n, mis_n, to_n;
  logic        redirect_bad;

  assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

  // Bus-side outputs are decoded straight from the state; pc is frozen while a read is in flight.
  assign memfetch_start = (state == S_REQ);
  assign bits_to_access = ((state == S_REQ) || (state == S_WAIT)) ? 4'b1111 : 4'b0000;
  assign addr           = ((state == S_REQ) || (state == S_WAIT)) ? pc : 32'h0000_0000;
  assign read_or_write  = 1'b0;

  // State register and all sequencer state, cleared asynchronously by IF_reset.
  always_ff @(posedge soc_clk or posedge IF_reset) begin
    if (IF_reset) begin
      state            <= S_IDLE;
      pc               <= RESET_PC;
      pend             <= 1'b0;
      pend_tgt         <= 32'h0000_0000;
      wait_cnt         <= 8'd0;
      instr_data       <= 32'h0000_0000;
      instr_pc         <= 32'h0000_0000;
      instr_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
      timeout_fault    <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      pend             <= pend_n;
      pend_tgt         <= pend_tgt_n;
      wait_cnt         <= wait_cnt_n;
      instr_data       <= data_n;
      instr_pc         <= ipc_n;
      instr_valid      <= valid_n;
      misaligned_fault <= mis_n;
      timeout_fault    <= to_n;
    end
  end

  // Next-state logic; a misaligned redirect overrides everything and parks the sequencer in FAULT.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_n     = pend;
    pend_tgt_n = pend_tgt;
    wait_cnt_n = wait_cnt;
    data_n     = instr_data;
    ipc_n      = instr_pc;
    valid_n    = instr_valid;
    mis_n      = misaligned_fault;
    to_n       = timeout_fault;

    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_n    = redirect_target;
          valid_n = 1'b0;
        end else if (!IF_stall) begin
          state_n = S_REQ;
        end
      end

      S_REQ: begin
        wait_cnt_n = 8'd0;
        if (redirect_valid) begin
          pend_n     = 1'b1;
          pend_tgt_n = redirect_target;
        end
        state_n = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt != 8'hFF) begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
        if (mem_done) begin
          if (pend || redirect_valid) begin
            pc_n    = redirect_valid ? redirect_target : pend_tgt;
            pend_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            data_n  = mem_rdata;
            ipc_n   = pc;
            valid_n = 1'b1;
            state_n = S_HOLD;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          to_n    = 1'b1;
          state_n = S_FAULT;
        end else if (redirect_valid) begin
          pend_n     = 1'b1;
          pend_tgt_n = redirect_target;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_target;
          valid_n = 1'b0;
          state_n = S_IDLE;
        end else if (decode_ready && !IF_stall) begin
          pc_n    = pc + 32'd4;
          valid_n = 1'b0;
          state_n = S_REQ;
        end
      end

      S_FAULT: begin
        valid_n = 1'b0;
      end

      default: begin
        state_n = S_FAULT;
        valid_n = 1'b0;
      end
    endcase

    if (redirect_bad) begin
      mis_n   = 1'b1;
      pc_n    = pc;
      pend_n  = 1'b0;
      valid_n = 1'b0;
      state_n = S_FAULT;
    end
  end

endmodule
